// File: rtl/uart_frame_mux.sv
// Frames CHANNELS snapshot words as sync, seq, payload, XOR checksum bytes
// and hands them to a UART transmitter over a valid/ready byte handshake.
module uart_frame_mux #(
    parameter int         CHANNELS  = 4,
    parameter int         WORD_W    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter bit         AUTO      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*WORD_W-1:0] data_in,
    input  logic                       send,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       frame_done,
    output logic [7:0]                 seq
);

    localparam int BPW    = WORD_W / 8;
    localparam int NBYTES = CHANNELS * BPW;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    if (CHANNELS < 1 || CHANNELS > 16 || WORD_W < 8 || WORD_W > 32 ||
        (WORD_W % 8) != 0) begin : g_bad_params
        $error("uart_frame_mux: illegal CHANNELS/WORD_W");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_DATA,
        S_CHK
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [CHANNELS*WORD_W-1:0]  r_snap;
    logic [CHANNELS*WORD_W-1:0]  w_payload;
    logic [CW-1:0]               r_idx;
    logic [7:0]                  r_chk;
    logic [7:0]                  r_seq;
    logic [7:0]                  w_byte;
    logic                        r_pend;
    logic                        r_done;
    logic                        w_start;

    // Channel 0 goes out first, so it lands in the top of the payload vector
    for (genvar k = 0; k < CHANNELS; k++) begin : g_order
        assign w_payload[(CHANNELS-1-k)*WORD_W +: WORD_W] =
            r_snap[k*WORD_W +: WORD_W];
    end

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == CW'(i)) begin
                w_byte = w_payload[(NBYTES-1-i)*8 +: 8];
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        w_start  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                tx_valid = 1'b0;
                w_start  = AUTO || send || r_pend;
                if (w_start) w_next = S_SYNC;
            end
            S_SYNC: begin
                tx_data = SYNC_BYTE;
                if (tx_ready) w_next = S_SEQ;
            end
            S_SEQ: begin
                tx_data = r_seq;
                if (tx_ready) w_next = S_DATA;
            end
            S_DATA: begin
                tx_data = w_byte;
                if (tx_ready && r_idx == LAST) w_next = S_CHK;
            end
            S_CHK: begin
                tx_data = r_chk;
                if (tx_ready) w_next = S_IDLE;
            end
            default: begin
                tx_valid = 1'b0;
                w_next   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap <= '0;
            r_idx  <= '0;
            r_chk  <= 8'h00;
            r_seq  <= 8'h00;
            r_pend <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_CHK) && tx_ready;
            if (w_start) begin
                r_snap <= data_in;
                r_pend <= 1'b0;
            end else if (send && AUTO == 1'b0) begin
                r_pend <= 1'b1;
            end
            if (r_state == S_SYNC && tx_ready) r_chk <= r_seq;
            if (r_state == S_SEQ && tx_ready) r_idx <= '0;
            if (r_state == S_DATA && tx_ready) begin
                r_chk <= r_chk ^ w_byte;
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_CHK && tx_ready) r_seq <= r_seq + 8'd1;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_done;
    assign seq        = r_seq;

endmodule

// File: tb/tb_uart_frame_mux.sv
// Bench for uart_frame_mux: triggered, free-running and single-byte builds
// against a byte-list frame model.
module tb_uart_frame_mux;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rmode    = 0;
    int seq_exp  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] m_din = '0;
    logic        m_send = 1'b0;
    logic        m_rdy = 1'b1;
    logic [7:0]  m_data, m_seq;
    logic        m_valid, m_busy, m_done;

    logic [31:0] a_din = '0;
    logic        a_send = 1'b0;
    logic        a_rdy = 1'b1;
    logic [7:0]  a_data, a_seq;
    logic        a_valid, a_busy, a_done;

    logic [7:0]  s_din = '0;
    logic        s_send = 1'b0;
    logic        s_rdy = 1'b1;
    logic [7:0]  s_data, s_seq;
    logic        s_valid, s_busy, s_done;

    uart_frame_mux #(.CHANNELS(2), .WORD_W(16), .AUTO(1'b0)) u_m (
        .clk(clk), .rst(rst), .data_in(m_din), .send(m_send),
        .tx_data(m_data), .tx_valid(m_valid), .tx_ready(m_rdy),
        .busy(m_busy), .frame_done(m_done), .seq(m_seq)
    );

    uart_frame_mux #(.CHANNELS(2), .WORD_W(16), .AUTO(1'b1)) u_a (
        .clk(clk), .rst(rst), .data_in(a_din), .send(a_send),
        .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_rdy),
        .busy(a_busy), .frame_done(a_done), .seq(a_seq)
    );

    uart_frame_mux #(.CHANNELS(1), .WORD_W(8), .AUTO(1'b0)) u_s (
        .clk(clk), .rst(rst), .data_in(s_din), .send(s_send),
        .tx_data(s_data), .tx_valid(s_valid), .tx_ready(s_rdy),
        .busy(s_busy), .frame_done(s_done), .seq(s_seq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame = sync, seq, words channel 0 first MSB first, XOR of seq+payload
    function automatic bq_t mk_frame(input logic [7:0] sq,
                                     input logic [63:0] d,
                                     input int nch, input int ww);
        bq_t        q;
        logic [7:0] c;
        logic [7:0] b;
        logic [63:0] w;
        q.push_back(8'hA5);
        q.push_back(sq);
        c = sq;
        for (int ch = 0; ch < nch; ch++) begin
            w = d >> (ch * ww);
            for (int k = ww / 8 - 1; k >= 0; k--) begin
                b = 8'(w >> (k * 8));
                q.push_back(b);
                c = c ^ b;
            end
        end
        q.push_back(c);
        return q;
    endfunction

    bq_t m_q, a_q, s_q;
    int  a_cyc[$];
    int  m_done_cnt = 0;
    int  m_last_x   = 0;
    int  m_done_cyc = 0;
    logic       m_stall = 1'b0;
    logic [7:0] m_hold  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            m_stall = 1'b0;
        end else begin
            if (m_stall)
                check("stall_hold", {23'd0, m_valid, m_data},
                      {23'd0, 1'b1, m_hold});
            if (m_valid && m_rdy) begin
                m_q.push_back(m_data);
                m_last_x = cyc;
            end
            if (m_done) begin
                m_done_cnt++;
                m_done_cyc = cyc;
            end
            m_stall = m_valid && !m_rdy;
            m_hold  = m_data;
        end
    end

    always @(negedge clk) begin
        if (rst && a_valid && a_rdy) begin
            a_q.push_back(a_data);
            a_cyc.push_back(cyc);
        end
        if (rst && s_valid && s_rdy) s_q.push_back(s_data);
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       m_rdy = 1'b1;
            1:       m_rdy = ~m_rdy;
            default: m_rdy = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n, input int max);
        int base;
        base = m_done_cnt;
        for (int i = 0; i < max && m_done_cnt < base + n; i++)
            @(posedge clk);
        check("done_count", m_done_cnt - base, n);
    endtask

    task automatic cmp(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(tag, {24'd0, got[i]}, {24'd0, exp[i]});
    endtask

    initial begin
        bq_t e;
        int  base;
        a_din = $urandom;

        #3;
        check("rst_valid", m_valid, 0);
        check("rst_busy", m_busy, 0);
        check("rst_done", m_done, 0);
        check("rst_seq", m_seq, 0);
        check("rst_data", m_data, 0);
        check("rst_auto_busy", a_busy, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Basic frame with latency check
        m_din = {16'hABCD, 16'h1234};
        tick();
        m_q.delete();
        m_send = 1'b1;
        @(negedge clk);
        check("pre_sync_valid", m_valid, 0);
        tick();
        m_send = 1'b0;
        @(negedge clk);
        check("latency_sync", {m_valid, m_data}, {1'b1, 8'hA5});
        check("busy_in_frame", m_busy, 1);
        wait_done(1, 40);
        cmp("basic", m_q, mk_frame(8'h00, {32'd0, m_din}, 2, 16));
        check("done_after_chk", m_done_cyc - m_last_x, 1);
        tick();
        tick();
        check("seq_after", m_seq, 1);
        check("done_once", m_done_cnt, 1);
        check("idle_busy", m_busy, 0);
        seq_exp = 2;

        // Toggling ready
        rmode = 1;
        m_q.delete();
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        wait_done(1, 60);
        cmp("toggle", m_q, mk_frame(8'h01, {32'd0, m_din}, 2, 16));
        rmode = 0;
        tick();
        tick();

        // Multiple sends mid-frame merge into one pending frame
        m_q.delete();
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        tick();
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        m_din  = $urandom;
        tick();
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        m_din  = {16'h0002, 16'h0001};
        tick();
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        wait_done(2, 60);
        e = mk_frame(8'h02, {32'd0, 16'hABCD, 16'h1234}, 2, 16);
        e = {e, mk_frame(8'h03, {32'd0, 16'h0002, 16'h0001}, 2, 16)};
        repeat (20) tick();
        cmp("pending", m_q, e);
        check("no_extra_busy", m_busy, 0);

        // Send coincident with the checksum transfer
        m_q.delete();
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        repeat (6) tick();
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        wait_done(2, 60);
        e = mk_frame(8'h04, {32'd0, m_din}, 2, 16);
        e = {e, mk_frame(8'h05, {32'd0, m_din}, 2, 16)};
        cmp("chk_send", m_q, e);
        seq_exp = 6;

        // Random data and random backpressure
        rmode = 2;
        for (int f = 0; f < 12; f++) begin
            tick();
            m_din = $urandom;
            e = mk_frame(8'(seq_exp), {32'd0, m_din}, 2, 16);
            m_q.delete();
            m_send = 1'b1;
            tick();
            m_send = 1'b0;
            m_din  = $urandom;
            wait_done(1, 200);
            cmp("random", m_q, e);
            seq_exp++;
        end
        rmode = 0;
        tick();
        check("seq_random", m_seq, 32'(seq_exp & 8'hFF));

        // Single 8-bit channel
        s_din = 8'h5A;
        s_q.delete();
        s_send = 1'b1;
        tick();
        s_send = 1'b0;
        repeat (10) tick();
        cmp("small", s_q, mk_frame(8'h00, 64'h5A, 1, 8));
        check("small_seq", s_seq, 1);

        // Free-running: 257 frames, seq wraps, one idle cycle between
        for (int i = 0; i < 5000 && a_q.size() < 257 * 7; i++)
            @(posedge clk);
        check("auto_len", a_q.size() >= 257 * 7, 1);
        for (int fr = 0; fr < 257; fr++) begin
            if (fr * 7 + 6 < a_q.size()) begin
                e = mk_frame(8'(fr), {32'd0, a_din}, 2, 16);
                for (int b = 0; b < 7; b++)
                    check("auto_byte", {24'd0, a_q[fr*7+b]}, {24'd0, e[b]});
                if (fr > 0)
                    check("auto_gap", a_cyc[fr*7] - a_cyc[(fr-1)*7], 8);
            end
        end

        // Asynchronous reset during payload byte 2
        tick();
        m_din = {16'hABCD, 16'h1234};
        base  = m_done_cnt;
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        repeat (4) tick();
        check("pre_rst_byte", m_data, 8'hAB);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_busy", m_busy, 0);
        check("arst_seq", m_seq, 0);
        check("arst_done", m_done, 0);
        check("arst_data", m_data, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        tick();
        check("no_abort_done", m_done_cnt - base, 0);
        m_q.delete();
        m_send = 1'b1;
        tick();
        m_send = 1'b0;
        wait_done(1, 40);
        cmp("post_rst", m_q, mk_frame(8'h00, {32'd0, m_din}, 2, 16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_mux.md
Name: uart_frame_mux

Overview:
- Parametrised packetiser between game-state registers and the UART byte transmitter.
- Snapshots CHANNELS words of WORD_W bits and serialises them into one byte-oriented frame: sync byte, sequence number, payload, XOR checksum.
- Uses a valid/ready byte handshake toward the UART.
- Generalises the fixed two-word, 16-bit UART mux to any channel count and word width. Adds framing, sequence numbering, checksum and triggered/free-running modes.

Parameters:
- CHANNELS, 4, number of words per frame; legal 1..16.
- WORD_W, 16, bits per word; must be a multiple of 8, legal 8..32.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- AUTO, 0, 1 = free-running (new frame starts whenever idle); 0 = frame only on send.

Ports:
- clk  in  1  system clock (clk65MHz domain).
- rst  in  1  asynchronous, active-low reset.
- data_in  in  CHANNELS*WORD_W  channel words; channel k at bits [k*WORD_W +: WORD_W].
- send  in  1  frame request, sampled every cycle; ignored when AUTO=1.
- tx_data  out  8  byte to UART.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_ready  in  1  UART accepts the byte this cycle.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when the checksum byte is accepted.
- seq  out  8  sequence number of the next frame.

Behaviour:
- Derived constants:
  - BPW = WORD_W/8.
  - NBYTES = CHANNELS*BPW.
  - Byte counter width = clog2(NBYTES), minimum 1.
- Elaboration check: illegal CHANNELS/WORD_W stops elaboration via $error.
- Transfer rule: a byte transfers in a cycle with tx_valid=1 and tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable. tx_valid never drops without a transfer.
- States: IDLE, SYNC, SEQ, DATA, CHK.
- IDLE:
  - Start condition: (AUTO=1) or send=1 or pending=1.
  - On start: latch data_in into the snapshot register and clear pending. Next cycle the state is SYNC, with tx_valid=1 and tx_data=SYNC_BYTE.
  - Latency: send in cycle N gives a SYNC byte on tx_data in cycle N+1.
- SYNC: on transfer go to SEQ, drive tx_data=seq, set chk=seq.
- SEQ: on transfer go to DATA, byte index 0.
- DATA:
  - Byte order: channel 0 first, each word most-significant byte first.
  - Byte i = snapshot[(NBYTES-1-i)... ] ordered as above. Equivalent: frame payload = {ch0 MSB..LSB, ch1 MSB..LSB, ...}.
  - On each payload transfer, chk ^= byte.
  - After byte NBYTES-1 transfers, go to CHK with tx_data = final chk.
- CHK: on transfer:
  - frame_done=1 for exactly that next cycle.
  - seq increments, wrapping 8'hFF -> 8'h00.
  - State returns to IDLE. A pending or AUTO request starts the next frame after one IDLE cycle.
- busy = 1 in SYNC/SEQ/DATA/CHK, 0 in IDLE.
- Checksum: XOR of the seq byte and all payload bytes. SYNC_BYTE is excluded.
- Snapshot: data_in changes during a frame do not affect the frame in flight.
- send while busy: sets a one-deep pending flag. Further sends while pending are merged. The pending frame snapshots data_in at its own start, not at request time.
- send in the same cycle as CHK transfer: sets pending; the frame follows.
- Reset (rst=0, asynchronous), any state:
  - State=IDLE, tx_valid=0, tx_data=0, busy=0, frame_done=0, seq=0, pending=0, snapshot=0, chk=0.
  - A partially sent frame is abandoned, with no completion pulse.
- After rst deasserts: first start condition no earlier than the first clk edge with rst=1.

Test Plan:
- CHANNELS=2, WORD_W=16, AUTO=0, tx_ready=1, ch0=16'h1234, ch1=16'hABCD, one send pulse -> tx bytes A5,00,12,34,AB,CD,40 on consecutive cycles starting one cycle after send; frame_done one cycle after 40 transfers; seq=1.
- Same setup, tx_ready toggling 1/0 every cycle -> identical byte sequence; tx_data stable across every stalled cycle; no duplicate or lost bytes.
- send pulsed three times mid-frame, data_in changed to ch0=16'h0001, ch1=16'h0002 mid-frame -> current frame unchanged; exactly one extra frame follows: A5,01,00,01,00,02,02.
- AUTO=1, tx_ready=1, 256 frames -> seq field runs 00..FF then 00; checksums correct; exactly one IDLE cycle between frames.
- rst asserted during DATA byte 2 -> tx_valid, busy, seq, frame_done all 0 immediately, without waiting for a clk edge; after release, next send produces a full frame with seq 00.
- CHANNELS=1, WORD_W=8, data 8'h5A -> A5,00,5A,5A.
